// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package instr_fetch_pkg;

    localparam int          INSTR_WIDTH      = 32;
    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [INSTR_WIDTH-1:0] instr_t;

    // All-zero word is the NOP shown to decode while nothing is valid.
    localparam instr_t NOP = '0;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO with push/pop/flush, used for fetched words and in-flight PCs.
// Latency: a pushed entry is visible at head_data/!empty one cycle after the push edge.
// Backpressure: push is accepted while not full, or while full with a same-cycle pop.
//
// Ports: clk, rst_n (async active-low); push/push_data in; pop in (ignored when
// empty); flush in (clears all entries, wins over push/pop); head_data, full,
// empty, count out.
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: nothing reads it until count says it is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: holds the PC, issues credit-limited word reads, buffers returns for decode.
// Latency: req 1 cycle after reset release; grant->rvalid >=1 cycle; rvalid->instr_valid 1 cycle.
// Backpressure: reads issue only while buffered + outstanding < FIFO_DEPTH, so decode stalls never overrun.
//
// Ports: clk, rst_n (async active-low); imem_req/imem_addr out, imem_gnt/imem_rvalid/
// imem_rdata in (responses in grant order); redirect/redirect_pc in (taken branch or
// jump, low two address bits ignored); instr_valid/instr/instr_pc out, instr_ready in.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [31:0]            instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc
);

    localparam int                    CW         = $clog2(FIFO_DEPTH + 1);
    localparam int                    EW         = INSTR_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [CW:0]           DEPTH_W    = (CW + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  req_q;
    logic [CW-1:0]         drop_cnt;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         occupancy;
    logic [CW-1:0]         out_next;
    logic [CW-1:0]         occ_next;
    logic                  credit_next;

    logic                  pcq_full;
    logic                  pcq_empty;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic                  ibuf_full;
    logic                  ibuf_empty;
    logic [EW-1:0]         head;
    instr_t                head_instr;

    logic                  fire;
    logic                  rsp;
    logic                  keep;
    logic                  push;
    logic                  pop;

    assign fire = req_q && imem_gnt && !pcq_full;
    // A response with nothing in flight (e.g. one issued before reset) is ignored.
    assign rsp  = imem_rvalid && !pcq_empty;
    assign keep = rsp && (drop_cnt == '0);
    assign pop  = instr_valid && instr_ready;
    assign push = keep && !redirect && (!ibuf_full || pop);

    // Credits are judged on next-cycle state so the registered req is exact.
    // Stale requests awaiting drop stay in outstanding, so they hold credits too.
    assign out_next    = outstanding + CW'(fire) - CW'(rsp);
    assign occ_next    = redirect ? '0 : occupancy + CW'(push) - CW'(pop);
    assign credit_next = ({1'b0, occ_next} + {1'b0, out_next}) < DEPTH_W;

    // In-flight PC queue: its occupancy is the outstanding-request count.
    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fire),
        .push_data (fetch_pc),
        .pop       (rsp),
        .flush     (1'b0),
        .head_data (rsp_pc),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (outstanding)
    );

    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem_rdata, rsp_pc}),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head),
        .full      (ibuf_full),
        .empty     (ibuf_empty),
        .count     (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= 1'b0;
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            req_q <= credit_next;

            if (redirect) begin
                fetch_pc <= redirect_pc & ALIGN_MASK;
            end else if (fire) begin
                fetch_pc <= fetch_pc + PC_INC;
            end

            // Everything still in flight after this edge belongs to the old path.
            if (redirect) begin
                drop_cnt <= out_next;
            end else if (rsp && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc;
    assign instr_valid = !ibuf_empty;
    assign head_instr  = head[EW-1:ADDR_WIDTH];
    assign instr       = instr_valid ? head_instr : NOP;
    assign instr_pc    = instr_valid ? head[ADDR_WIDTH-1:0] : RESET_PC;

endmodule
